// File: rtl/uart_cmd_pkg.sv
// Shared constants and state encoding for the UART command responder.
package uart_cmd_pkg;

  localparam logic [7:0] CmdStatus = 8'h00;
  localparam logic [7:0] CmdTemp   = 8'h01;
  localparam logic [7:0] CmdHum    = 8'h02;

  localparam logic [7:0] RspOk        = 8'h00;
  localparam logic [7:0] RspHum       = 8'h08;
  localparam logic [7:0] RspTemp      = 8'h09;
  localparam logic [7:0] RspSensorErr = 8'h1F;
  localparam logic [7:0] RspBadAddr   = 8'hDF;
  localparam logic [7:0] RspBadCmd    = 8'hFF;

  localparam logic [7:0] MaxAddr = 8'h1F;

  // Encoding is exported on o_State for LED debug, so values are pinned.
  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StGetAddr   = 3'd1,
    StReqSensor = 3'd2,
    StSendCode  = 3'd3,
    StWaitCode  = 3'd4,
    StSendData  = 3'd5,
    StWaitData  = 3'd6
  } state_e;

endpackage

// File: rtl/uart_timeout_counter.sv
// Saturating phase timer: counts enabled cycles since the last clear and
// pulses expired_o once, on the limit_i-th enabled cycle.
module uart_timeout_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic [Width-1:0] limit_i,
  output logic             expired_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != limit_i)) begin
      count_d = count_q + Width'(1);
    end
  end

  // Once saturated at limit_i the compare below can no longer match.
  assign expired_o = enable_i && (count_q == (limit_i - Width'(1)));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_cmd_responder.sv
// Answers 2-byte UART requests (command, sensor address) with a 2-byte
// response (code, data) after fetching one reading from the sensor front-end.
module uart_cmd_responder #(
  parameter int unsigned CLKS_PER_BIT        = 5208,
  parameter int unsigned BYTE_TIMEOUT_CLKS   = 20 * CLKS_PER_BIT,
  parameter int unsigned SENSOR_TIMEOUT_CLKS = 50_000_000
) (
  input  logic        i_Clock,
  input  logic        i_Rst_n,
  input  logic        i_Rx_DV,
  input  logic [7:0]  i_Rx_Byte,
  input  logic        i_Tx_Active,
  input  logic        i_Tx_Done,
  output logic        o_Tx_DV,
  output logic [7:0]  o_Tx_Byte,
  output logic        o_Sensor_Req,
  output logic [4:0]  o_Sensor_Addr,
  input  logic        i_Sensor_Ack,
  input  logic [15:0] i_Sensor_Data,
  input  logic        i_Sensor_Err,
  output logic        o_Busy,
  output logic [2:0]  o_State
);

  import uart_cmd_pkg::*;

  localparam int unsigned MaxTimeout = (BYTE_TIMEOUT_CLKS > SENSOR_TIMEOUT_CLKS) ?
                                       BYTE_TIMEOUT_CLKS : SENSOR_TIMEOUT_CLKS;
  localparam int unsigned TimerWidth = $clog2(MaxTimeout + 1);

  state_e           state_q, state_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [4:0]       addr_q, addr_d;
  logic [7:0]       code_q, code_d;
  logic [7:0]       data_q, data_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic             tx_dv_q, tx_dv_d;

  logic                  timer_en;
  logic                  timer_clr;
  logic                  timer_expired;
  logic [TimerWidth-1:0] timer_limit;

  // One timer serves both waiting phases; it restarts on every state change.
  assign timer_en    = (state_q == StGetAddr) || (state_q == StReqSensor);
  assign timer_clr   = (state_d != state_q);
  assign timer_limit = (state_q == StReqSensor) ? TimerWidth'(SENSOR_TIMEOUT_CLKS)
                                                : TimerWidth'(BYTE_TIMEOUT_CLKS);

  uart_timeout_counter #(
    .Width(TimerWidth)
  ) u_timeout (
    .clk_i    (i_Clock),
    .rst_ni   (i_Rst_n),
    .clear_i  (timer_clr),
    .enable_i (timer_en),
    .limit_i  (timer_limit),
    .expired_o(timer_expired)
  );

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    code_d    = code_q;
    data_d    = data_q;
    tx_dv_d   = 1'b0;
    tx_byte_d = tx_byte_q;

    unique case (state_q)
      StIdle: begin
        if (i_Rx_DV) begin
          cmd_d   = i_Rx_Byte;
          state_d = StGetAddr;
        end
      end
      StGetAddr: begin
        if (i_Rx_DV) begin
          addr_d = i_Rx_Byte[4:0];
          if (cmd_q > CmdHum) begin
            code_d  = RspBadCmd;
            data_d  = 8'h00;
            state_d = StSendCode;
          end else if (i_Rx_Byte > MaxAddr) begin
            code_d  = RspBadAddr;
            data_d  = 8'h00;
            state_d = StSendCode;
          end else begin
            state_d = StReqSensor;
          end
        end else if (timer_expired) begin
          state_d = StIdle;
        end
      end
      StReqSensor: begin
        // Ack is tested first so it wins over a coincident timeout.
        if (i_Sensor_Ack) begin
          state_d = StSendCode;
          data_d  = 8'h00;
          if (i_Sensor_Err) begin
            code_d = RspSensorErr;
          end else begin
            case (cmd_q)
              CmdStatus: code_d = RspOk;
              CmdTemp: begin
                code_d = RspTemp;
                data_d = i_Sensor_Data[7:0];
              end
              default: begin
                code_d = RspHum;
                data_d = i_Sensor_Data[15:8];
              end
            endcase
          end
        end else if (timer_expired) begin
          code_d  = RspSensorErr;
          data_d  = 8'h00;
          state_d = StSendCode;
        end
      end
      StSendCode: begin
        if (!i_Tx_Active) begin
          tx_dv_d   = 1'b1;
          tx_byte_d = code_q;
          state_d   = StWaitCode;
        end
      end
      StWaitCode: begin
        if (i_Tx_Done) state_d = StSendData;
      end
      StSendData: begin
        if (!i_Tx_Active) begin
          tx_dv_d   = 1'b1;
          tx_byte_d = data_q;
          state_d   = StWaitData;
        end
      end
      StWaitData: begin
        if (i_Tx_Done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q   <= StIdle;
      cmd_q     <= 8'h00;
      addr_q    <= 5'h00;
      code_q    <= 8'h00;
      data_q    <= 8'h00;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      code_q    <= code_d;
      data_q    <= data_d;
      tx_dv_q   <= tx_dv_d;
      tx_byte_q <= tx_byte_d;
    end
  end

  assign o_Tx_DV       = tx_dv_q;
  assign o_Tx_Byte     = tx_byte_q;
  assign o_Sensor_Req  = (state_q == StReqSensor);
  assign o_Sensor_Addr = addr_q;
  assign o_Busy        = (state_q != StIdle);
  assign o_State       = state_q;

endmodule
